// File: rtl/muldiv_unit.sv
// Multiply/divide unit: operand capture with bus snooping, MUL_STAGES-cycle multiply, XLEN-cycle restoring divide.
// Result held in DONE until wb_ack; a load while busy is dropped, and flush returns to IDLE from any state.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [4:0]      rd,
    input  logic [5:0]      ex_type,
    input  logic [XLEN:0]   data1,
    input  logic [XLEN:0]   data2,
    input  logic [1:0]      data1_depend,
    input  logic [1:0]      data2_depend,
    input  logic [XLEN:0]   alu_data,
    input  logic [XLEN:0]   lsu_data,
    input  logic            flush,
    input  logic            wb_ack,
    output logic [1:0]      state,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            illegal
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [5:0] OP_MUL = 6'd29, OP_MULHU = 6'd30, OP_DIVU = 6'd31, OP_REMU = 6'd32;
    localparam logic [5:0] OP_MULH = 6'd33, OP_MULHSU = 6'd34, OP_DIV = 6'd35, OP_REM = 6'd36;

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_WAIT = 2'b01, S_EXEC = 2'b10, S_DONE = 2'b11} state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_a, r_b, r_quo, r_rem, r_result;
    logic            r_a_vld, r_b_vld, r_illegal;
    logic [1:0]      r_src1, r_src2;
    logic [5:0]      r_op;
    logic [4:0]      r_rd;
    logic [CW-1:0]   r_cnt, w_cnt_init;

    logic [XLEN:0]   w_ld1, w_ld2, w_bus1, w_bus2;
    logic            w_legal, w_accept, w_a_vld, w_b_vld;
    logic [XLEN-1:0] w_a, w_b;
    logic            w_is_div, w_is_rem, w_sdiv, w_div0, w_ovf, w_neg_a, w_neg_b;
    logic [XLEN-1:0] w_mag_a, w_mag_b, w_quo_nxt, w_rem_nxt, w_q_fix, w_r_fix, w_res;
    logic [XLEN:0]   w_shift, w_diff;
    logic [2*XLEN-1:0] w_ma, w_mb, w_prod;

    // Source 10 falls back to the register-file operand, same as 00.
    assign w_ld1  = (data1_depend == 2'b01) ? alu_data : (data1_depend == 2'b11) ? lsu_data : data1;
    assign w_ld2  = (data2_depend == 2'b01) ? alu_data : (data2_depend == 2'b11) ? lsu_data : data2;
    assign w_bus1 = (r_src1 == 2'b01) ? alu_data : (r_src1 == 2'b11) ? lsu_data : data1;
    assign w_bus2 = (r_src2 == 2'b01) ? alu_data : (r_src2 == 2'b11) ? lsu_data : data2;

    assign w_legal  = (ex_type >= OP_MUL) && (ex_type <= OP_REM);
    assign w_accept = load && (r_state == S_IDLE) && w_legal && !flush;

    // A slot is usable in the same cycle its bus first shows valid, so EXEC can start then.
    assign w_a_vld = r_a_vld || w_bus1[XLEN];
    assign w_b_vld = r_b_vld || w_bus2[XLEN];
    assign w_a     = r_a_vld ? r_a : w_bus1[XLEN-1:0];
    assign w_b     = r_b_vld ? r_b : w_bus2[XLEN-1:0];

    assign w_is_div = (r_op == OP_DIVU) || (r_op == OP_REMU) || (r_op == OP_DIV) || (r_op == OP_REM);
    assign w_is_rem = (r_op == OP_REMU) || (r_op == OP_REM);
    assign w_sdiv   = (r_op == OP_DIV) || (r_op == OP_REM);
    assign w_div0   = (w_b == '0);
    assign w_ovf    = w_sdiv && (w_a == {1'b1, {(XLEN-1){1'b0}}}) && (w_b == '1);
    assign w_neg_a  = w_sdiv && w_a[XLEN-1];
    assign w_neg_b  = w_sdiv && w_b[XLEN-1];
    assign w_mag_a  = w_neg_a ? -w_a : w_a;
    assign w_mag_b  = w_neg_b ? -w_b : w_b;

    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, w_mag_b};
    assign w_rem_nxt = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    assign w_quo_nxt = {r_quo[XLEN-2:0], ~w_diff[XLEN]};
    assign w_q_fix   = (w_neg_a ^ w_neg_b) ? -w_quo_nxt : w_quo_nxt;
    assign w_r_fix   = w_neg_a ? -w_rem_nxt : w_rem_nxt;

    // Operands sign- or zero-extended to full product width; the low 2*XLEN bits are exact either way.
    assign w_ma   = {{XLEN{((r_op == OP_MULH) || (r_op == OP_MULHSU)) && w_a[XLEN-1]}}, w_a};
    assign w_mb   = {{XLEN{(r_op == OP_MULH) && w_b[XLEN-1]}}, w_b};
    assign w_prod = w_ma * w_mb;

    always_comb begin
        w_res = '0;
        if (!w_is_div)      w_res = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        else if (w_div0)    w_res = w_is_rem ? w_a : '1;
        else if (w_ovf)     w_res = w_is_rem ? '0 : w_a;
        else                w_res = w_is_rem ? w_r_fix : w_q_fix;
    end

    always_comb begin
        w_cnt_init = CW'(MUL_STAGES - 1);
        if (w_is_div) w_cnt_init = (w_div0 || w_ovf) ? '0 : CW'(XLEN - 1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_WAIT;
            S_WAIT: if (w_a_vld && w_b_vld) w_state_nxt = S_EXEC;
            S_EXEC: if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE: if (wb_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0; r_b <= '0; r_a_vld <= 1'b0; r_b_vld <= 1'b0;
            r_src1 <= '0; r_src2 <= '0; r_op <= '0; r_rd <= '0;
            r_cnt <= '0; r_quo <= '0; r_rem <= '0; r_result <= '0; r_illegal <= 1'b0;
        end else begin
            r_illegal <= load && (r_state == S_IDLE) && !w_legal && !flush;
            if (flush) begin
                r_a <= '0; r_b <= '0; r_a_vld <= 1'b0; r_b_vld <= 1'b0;
                r_src1 <= '0; r_src2 <= '0;
            end else if (w_accept) begin
                r_a_vld <= w_ld1[XLEN];
                r_b_vld <= w_ld2[XLEN];
                r_a     <= w_ld1[XLEN] ? w_ld1[XLEN-1:0] : '0;
                r_b     <= w_ld2[XLEN] ? w_ld2[XLEN-1:0] : '0;
                r_src1  <= data1_depend;
                r_src2  <= data2_depend;
                r_op    <= ex_type;
                r_rd    <= rd;
            end else if (r_state == S_WAIT) begin
                if (!r_a_vld && w_bus1[XLEN]) begin r_a <= w_bus1[XLEN-1:0]; r_a_vld <= 1'b1; end
                if (!r_b_vld && w_bus2[XLEN]) begin r_b <= w_bus2[XLEN-1:0]; r_b_vld <= 1'b1; end
                if (w_a_vld && w_b_vld) begin
                    r_cnt <= w_cnt_init;
                    r_quo <= w_mag_a;
                    r_rem <= '0;
                end
            end else if (r_state == S_EXEC) begin
                r_cnt <= r_cnt - CW'(1);
                if (w_is_div) begin
                    r_quo <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                end
                if (r_cnt == '0) r_result <= w_res;
            end
        end
    end

    assign state   = r_state;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign result  = done ? r_result : '0;
    assign rd_out  = done ? r_rd : '0;
    assign illegal = r_illegal;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multiply/divide functional unit for the scoreboard pipeline, the next generation of the single-cycle MUL unit. It accepts one issued M-extension instruction at a time, captures each operand from the register file or snoops the ALU/LSU result buses until it is valid, executes on a pipelined multiplier or an iterative radix-2 divider, and holds the result until writeback accepts it. Signed and unsigned variants, divide-by-zero/overflow rules, flush and a writeback handshake are new relative to the previous unit.

## Interface

- XLEN, 32, datapath width; every bus carries a valid bit at [XLEN]
- MUL_STAGES, 2, multiplier latency in EXEC cycles, legal 1..4

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- load  in  1  issue strobe, honoured only in IDLE
- rd  in  5  destination register of issued op
- ex_type  in  6  opcode: 29 MUL, 30 MULHU, 31 DIVU, 32 REMU, 33 MULH, 34 MULHSU, 35 DIV, 36 REM
- data1, data2  in  XLEN+1  register-file operands, [XLEN] = valid
- data1_depend, data2_depend  in  2  source: 00 data, 01 ALU bus, 11 LSU bus, 10 treated as 00
- alu_data, lsu_data  in  XLEN+1  forwarding buses, [XLEN] = valid
- flush  in  1  discard current op
- wb_ack  in  1  writeback accepts result
- state  out  2  00 IDLE, 01 WAIT, 10 EXEC, 11 DONE
- busy  out  1  state != IDLE
- done  out  1  state == DONE
- result  out  XLEN  result, 0 unless DONE
- rd_out  out  5  rd of result, 0 unless DONE
- illegal  out  1  one-cycle pulse: load with ex_type outside 29..36

## Operation

- Two operand slots {value, valid, src}. On accepted load: src <- depend; src 00 captures data with its valid bit; src 01/11 captures the selected bus if its valid bit is set, else marks invalid.
- Invalid slot captures its bus on the first cycle the bus valid bit is 1, then freezes; later bus traffic never overwrites a valid slot.
- FSM: IDLE -load & legal-> WAIT; WAIT -both slots valid-> EXEC; EXEC -counter expires-> DONE; DONE -wb_ack-> IDLE.
- Illegal ex_type: illegal pulses next cycle, state stays IDLE, nothing captured.
- load while busy is ignored; no queueing.
- Multiply: XLEN x XLEN -> 2*XLEN product; MUL low half, MULH/MULHU/MULHSU high half with signed x signed, unsigned x unsigned, signed x unsigned operands.
- Divide: restoring shift-subtract on magnitudes, one quotient bit per cycle, XLEN EXEC cycles; signed ops fix up signs (quotient negative if signs differ, remainder takes dividend sign).
- Divisor 0: DIVU/DIV -> all ones, REMU/REM -> dividend; 1 EXEC cycle.
- DIV/REM with dividend = -2^(XLEN-1), divisor = -1: quotient = dividend, remainder 0; 1 EXEC cycle.
- DONE holds result/rd_out stable until wb_ack.
- flush: from any state, next state IDLE, slots cleared; priority flush > wb_ack > load.
- Reset: state IDLE, slots/counter/result registers 0, every output 0.

## Timing

- Cycle 0: load sampled. Cycle 1: WAIT (slots reflect cycle-0 captures).
- Both operands valid at issue: EXEC from cycle 2; multiply DONE at cycle 2+MUL_STAGES; divide DONE at cycle 2+XLEN; special-case divide DONE at cycle 3.
- Bus valid first seen in cycle k >= 1: slot valid from cycle k+1, EXEC no earlier than k+1.
- wb_ack in DONE cycle n: IDLE in n+1; new load accepted in n+1, never in n.
- wb_ack outside DONE has no effect; load and flush in the same cycle: flush wins, load dropped.
- rst_n low mid-op: immediate return to reset values, no done pulse.

## Test plan

- MUL 7 x 6, both src 00, MUL_STAGES=2: done in cycle 4, result 42, rd_out = rd; wb_ack -> IDLE next cycle.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0; MULHU same -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF.
- DIV -20 / 3 -> 0xFFFFFFFA, REM -> 0xFFFFFFFE, done at cycle 34; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, done at cycle 3; DIV 0x80000000 / -1 -> 0x80000000.
- data1 src 01, alu_data valid 9 in cycle 3 then 77 in cycle 4, data2 = 2, MUL: EXEC from cycle 4, result 18 (77 ignored).
- Hold DONE with wb_ack low 5 cycles: result/rd_out stable, load ignored; flush in WAIT and mid-divide -> IDLE next cycle, done never asserted.
- ex_type 40 with load: illegal one cycle, state 00; rst_n low in EXEC: all outputs 0 immediately.
